// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, RV32
// load/store funct3 codes and the MMIO addresses decoded by data_mem.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] LEDS_ADDR   = 32'hFFFF_FFFC;
    localparam logic [31:0] MILLIS_ADDR = 32'hFFFF_FFF8;
    localparam logic [31:0] MICROS_ADDR = 32'hFFFF_FFF4;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way combinational winner select. DMEM_ARB_RR_EN selects round-robin
// (rr_ptr = last winner) instead of fixed m0 priority.
module dmem_arb_pick (
    input  logic [1:0] valids,
`ifdef DMEM_ARB_RR_EN
    input  logic       rr_ptr,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
`ifdef DMEM_ARB_RR_EN
        // On a tie the requester that did not win last time goes first.
        if (valids == 2'b11)
            grant = rr_ptr ? 2'b01 : 2'b10;
        else
            grant = valids;
`else
        if (valids[0])
            grant = 2'b01;
        else if (valids[1])
            grant = 2'b10;
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_mem between m0 (core LSU) and m1 (loader/debug) with an
// IDLE/ISSUE/RESP sequence; define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WR_ACK = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_wren,
    input  logic [2:0]        m0_req_funct3,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_wren,
    input  logic [2:0]        m1_req_funct3,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic              dmem_wren,
    output logic [2:0]        funct3,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_data_in,
    input  logic [DATA_W-1:0] dmem_data_out
);

    arb_state_t        state;
    logic              cmd_wren;
    logic              cmd_owner;
    logic [2:0]        cmd_funct3;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              wren_q;
    logic              rsp_q;
    logic [1:0]        grant;
    logic              arb_open;
    logic              accept;
    logic              win;

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;

    dmem_arb_pick u_pick (
        .valids ('{m1_req_valid, m0_req_valid}),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );
`else
    dmem_arb_pick u_pick (
        .valids ({m1_req_valid, m0_req_valid}),
        .grant  (grant)
    );
`endif

    // Ready is gated by reset so nothing is accepted while the FSM is held.
    assign arb_open     = (state == IDLE) || (state == RESP);
    assign accept       = arb_open && (grant != 2'b00) && !reset;
    assign win          = grant[1];
    assign m0_req_ready = accept && grant[0];
    assign m1_req_ready = accept && grant[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cmd_wren   <= 1'b0;
            cmd_owner  <= 1'b0;
            cmd_funct3 <= '0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            wren_q     <= 1'b0;
            rsp_q      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            wren_q <= 1'b0;
            rsp_q  <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        cmd_owner  <= win;
                        cmd_wren   <= win ? m1_req_wren   : m0_req_wren;
                        cmd_funct3 <= win ? m1_req_funct3 : m0_req_funct3;
                        cmd_addr   <= win ? m1_req_addr   : m0_req_addr;
                        cmd_wdata  <= win ? m1_req_wdata  : m0_req_wdata;
                        wren_q     <= win ? m1_req_wren   : m0_req_wren;
`ifdef DMEM_ARB_RR_EN
                        rr_ptr     <= win;
`endif
                        state      <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    rsp_q <= !cmd_wren || (WR_ACK != 0);
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command registers stay on the bus through RESP so data_mem's MMIO
    // read mux still sees the address it was issued with.
    assign dmem_wren    = wren_q;
    assign funct3       = cmd_funct3;
    assign dmem_address = cmd_addr;
    assign dmem_data_in = cmd_wdata;

    assign m0_rsp_valid = rsp_q && !cmd_owner;
    assign m1_rsp_valid = rsp_q && cmd_owner;
    assign m0_rsp_rdata = (state == RESP && !cmd_owner) ? dmem_data_out : '0;
    assign m1_rsp_rdata = (state == RESP && cmd_owner)  ? dmem_data_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data_mem
// (word RAM + LEDS MMIO register, synchronous RAM read, live-address extract).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req_valid, m0_req_ready, m0_req_wren, m0_rsp_valid;
    logic [2:0]  m0_req_funct3;
    logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_wren, m1_rsp_valid;
    logic [2:0]  m1_req_funct3;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
    logic        dmem_wren;
    logic [2:0]  funct3;
    logic [31:0] dmem_address, dmem_data_in, dmem_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WR_ACK(1)) dut (
        .clk(clk), .reset(reset),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_wren(m0_req_wren),
        .m0_req_funct3(m0_req_funct3), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_wren(m1_req_wren),
        .m1_req_funct3(m1_req_funct3), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .dmem_wren(dmem_wren), .funct3(funct3), .dmem_address(dmem_address),
        .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out)
    );

    // Behavioural data_mem
    logic [31:0] mem [0:63];
    logic [31:0] leds;
    logic [31:0] rd_word_q;
    logic [31:0] wr_mask;
    logic [31:0] wr_data;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        leds      = 32'h0;
        rd_word_q = 32'h0;
    end

    always_comb begin
        wr_mask = 32'hFFFF_FFFF;
        wr_data = dmem_data_in;
        if (funct3[1:0] == 2'b00) begin
            wr_mask = 32'hFF << (8 * dmem_address[1:0]);
            wr_data = {24'h0, dmem_data_in[7:0]} << (8 * dmem_address[1:0]);
        end else if (funct3[1:0] == 2'b01) begin
            wr_mask = dmem_address[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            wr_data = dmem_address[1] ? {dmem_data_in[15:0], 16'h0} : {16'h0, dmem_data_in[15:0]};
        end
    end

    always @(posedge clk) begin
        if (dmem_wren) begin
            if (dmem_address[31:2] == 30'h3FFF_FFFF)
                leds <= (leds & ~wr_mask) | (wr_data & wr_mask);
            else
                mem[dmem_address[7:2]] <= (mem[dmem_address[7:2]] & ~wr_mask) | (wr_data & wr_mask);
        end
        rd_word_q <= mem[dmem_address[7:2]];
    end

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                                 input logic [2:0] f);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] sh;
        sh = w >> (8 * a);
        b  = sh[7:0];
        h  = a[1] ? w[31:16] : w[15:0];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    assign dmem_data_out = load_extract((dmem_address[31:2] == 30'h3FFF_FFFF) ? leds : rd_word_q,
                                        dmem_address[1:0], funct3);

    task automatic drive_req(input int m, input logic v, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        if (m == 0) begin
            m0_req_valid = v; m0_req_wren = wr; m0_req_funct3 = f3; m0_req_addr = addr; m0_req_wdata = wd;
        end else begin
            m1_req_valid = v; m1_req_wren = wr; m1_req_funct3 = f3; m1_req_addr = addr; m1_req_wdata = wd;
        end
    endtask

    // One complete access from master m; returns what was seen in ISSUE and RESP.
    task automatic applyStimulus(input int m, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output logic accepted, output logic early_rsp,
                                 output logic wren_issue, output logic wren_resp,
                                 output logic rsp_own, output logic rsp_other,
                                 output logic [31:0] rdata_own, output logic [31:0] rdata_other);
        int n;
        @(negedge clk);
        drive_req(m, 1'b1, wr, f3, addr, wd);
        #1;
        n = 0;
        while (((m == 0) ? m0_req_ready : m1_req_ready) !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        accepted    = ((m == 0) ? m0_req_ready : m1_req_ready) === 1'b1;
        early_rsp   = 1'b0; wren_issue = 1'b0; wren_resp = 1'b0;
        rsp_own     = 1'b0; rsp_other  = 1'b0;
        rdata_own   = 32'h0; rdata_other = 32'h0;
        if (!accepted) begin
            drive_req(m, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
            return;
        end
        @(posedge clk); #1;
        drive_req(m, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        @(negedge clk);
        early_rsp  = m0_rsp_valid | m1_rsp_valid;
        wren_issue = dmem_wren;
        @(negedge clk);
        wren_resp   = dmem_wren;
        rsp_own     = (m == 0) ? m0_rsp_valid : m1_rsp_valid;
        rsp_other   = (m == 0) ? m1_rsp_valid : m0_rsp_valid;
        rdata_own   = (m == 0) ? m0_rsp_rdata : m1_rsp_rdata;
        rdata_other = (m == 0) ? m1_rsp_rdata : m0_rsp_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_req(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        drive_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (m0_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=0", m0_req_ready); end
        checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp got=%b exp=00", {m0_rsp_valid, m1_rsp_valid}); end
        checks++; if (dmem_wren !== 1'b0) begin errors++; $display("[TB] FAIL reset_wren got=%b exp=0", dmem_wren); end
        checks++; if (dmem_address !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=0", dmem_address); end
        drive_req(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        logic acc, early, wi, wr, ro, rx;
        logic [31:0] d, dx;
        applyStimulus(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, acc, early, wi, wr, ro, rx, d, dx);
        checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL sw_accept got=%b exp=1", acc); end
        checks++; if (wi !== 1'b1) begin errors++; $display("[TB] FAIL sw_wren_issue got=%b exp=1", wi); end
        checks++; if (wr !== 1'b0) begin errors++; $display("[TB] FAIL sw_wren_resp got=%b exp=0", wr); end
        checks++; if (ro !== 1'b1) begin errors++; $display("[TB] FAIL sw_ack got=%b exp=1", ro); end
        applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, acc, early, wi, wr, ro, rx, d, dx);
        checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL lw_early_rsp got=%b exp=0", early); end
        checks++; if (wi !== 1'b0) begin errors++; $display("[TB] FAIL lw_wren got=%b exp=0", wi); end
        checks++; if (ro !== 1'b1) begin errors++; $display("[TB] FAIL lw_rsp_valid got=%b exp=1", ro); end
        checks++; if (rx !== 1'b0) begin errors++; $display("[TB] FAIL lw_m1_rsp got=%b exp=0", rx); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL lw_rdata got=%h exp=deadbeef", d); end
        checks++; if (dx !== 32'h0) begin errors++; $display("[TB] FAIL lw_m1_rdata got=%h exp=0", dx); end
    endtask

    task automatic test_arbitration();
        logic exp_r0, exp_r1, exp_v0, exp_v1;
        logic last_win;
        logic have_prev;
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        drive_req(1, 1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
        have_prev = 1'b0;
        last_win  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_r0 = 1'b0; exp_r1 = 1'b0;
            if (k % 2 == 0) begin
`ifdef DMEM_ARB_RR_EN
                exp_r1 = ((k / 2) % 2) == 0;
`else
                exp_r1 = 1'b0;
`endif
                exp_r0 = !exp_r1;
            end
            exp_v0 = (k % 2 == 0) && have_prev && !last_win;
            exp_v1 = (k % 2 == 0) && have_prev && last_win;
            checks++; if (m0_req_ready !== exp_r0) begin errors++; $display("[TB] FAIL arb_ready0 cyc=%0d got=%b exp=%b", k, m0_req_ready, exp_r0); end
            checks++; if (m1_req_ready !== exp_r1) begin errors++; $display("[TB] FAIL arb_ready1 cyc=%0d got=%b exp=%b", k, m1_req_ready, exp_r1); end
            checks++; if (m0_rsp_valid !== exp_v0) begin errors++; $display("[TB] FAIL arb_rsp0 cyc=%0d got=%b exp=%b", k, m0_rsp_valid, exp_v0); end
            checks++; if (m1_rsp_valid !== exp_v1) begin errors++; $display("[TB] FAIL arb_rsp1 cyc=%0d got=%b exp=%b", k, m1_rsp_valid, exp_v1); end
            if (k % 2 == 0) begin
                last_win  = exp_r1;
                have_prev = 1'b1;
            end
        end
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_mmio();
        logic acc, early, wi, wr, ro, rx;
        logic [31:0] d, dx;
        applyStimulus(1, 1'b1, 3'b000, 32'hFFFF_FFFE, 32'h80, acc, early, wi, wr, ro, rx, d, dx);
        checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL sb_accept got=%b exp=1", acc); end
        checks++; if (rx !== 1'b0) begin errors++; $display("[TB] FAIL sb_m0_rsp got=%b exp=0", rx); end
        applyStimulus(1, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, acc, early, wi, wr, ro, rx, d, dx);
        checks++; if (ro !== 1'b1) begin errors++; $display("[TB] FAIL leds_rsp got=%b exp=1", ro); end
        checks++; if (d !== 32'h0080_0000) begin errors++; $display("[TB] FAIL leds_rdata got=%h exp=00800000", d); end
        checks++; if (dx !== 32'h0) begin errors++; $display("[TB] FAIL leds_m0_rdata got=%h exp=0", dx); end
        checks++; if (leds[23:16] !== 8'h80) begin errors++; $display("[TB] FAIL leds_red got=%h exp=80", leds[23:16]); end
    endtask

    task automatic test_sign_extend();
        logic acc, early, wi, wr, ro, rx;
        logic [31:0] d, dx;
        logic [2:0]  f3s [4];
        logic [31:0] ads [4];
        logic [31:0] exps [4];
        f3s = '{3'b000, 3'b100, 3'b001, 3'b101};
        ads = '{32'h13, 32'h13, 32'h12, 32'h12};
        exps = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_F000, 32'h0000_F000};
        applyStimulus(0, 1'b1, 3'b010, 32'h10, 32'hF000_0000, acc, early, wi, wr, ro, rx, d, dx);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b0, f3s[i], ads[i], 32'h0, acc, early, wi, wr, ro, rx, d, dx);
            checks++; if (d !== exps[i]) begin errors++; $display("[TB] FAIL ext_rdata f3=%0d got=%h exp=%h", f3s[i], d, exps[i]); end
        end
    endtask

    task automatic test_reset_mid_access();
        logic acc, early, wi, wr, ro, rx;
        logic [31:0] d, dx;
        int n;
        @(negedge clk);
        drive_req(0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h1234_5678);
        #1;
        n = 0;
        while (m0_req_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        checks++; if (m0_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_accept got=%b exp=1", m0_req_ready); end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checks++; if (m0_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ready got=%b exp=0", m0_req_ready); end
        checks++; if (dmem_wren !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_wren got=%b exp=0", dmem_wren); end
        checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_rsp got=%b exp=00", {m0_rsp_valid, m1_rsp_valid}); end
        drive_req(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if ({m0_rsp_valid, m1_rsp_valid, dmem_wren} !== 3'b000) begin errors++; $display("[TB] FAIL rst_after cyc=%0d got=%b exp=000", k, {m0_rsp_valid, m1_rsp_valid, dmem_wren}); end
        end
        applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, acc, early, wi, wr, ro, rx, d, dx);
        checks++; if (ro !== 1'b1 || d !== 32'hF000_0000) begin errors++; $display("[TB] FAIL rst_recover got=%b/%h exp=1/f0000000", ro, d); end
    endtask

    task automatic checkOutput();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    initial begin
        reset = 1'b1;
        drive_req(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        test_reset();
        test_store_load();
        test_arbitration();
        test_mmio();
        test_sign_extend();
        test_reset_mid_access();
        checkOutput();
        $finish;
    end

endmodule
